// File: rtl/axi4_sram_slave_if.sv
// AXI4 (AXI3-style ID/WID, 4-bit LEN) bus bundle for the SRAM responder.
// Channels: AR (read address), R (read data), AW (write address),
// W (write data), B (write response). Clock and reset stay outside.
// Modports: master drives requests / consumes responses; slave the reverse.
interface axi4_sram_slave_if;
   // Read address channel
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   // Read data channel
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   // Write address channel
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready;
   // Write data channel
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   // Write response channel
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/axi4_sram_slave.sv
// AXI4 memory responder backed by a word-addressed RAM of 2^ADDR_WIDTH
// 32-bit words. One transaction (read or write) in flight at a time;
// FIXED and INCR bursts up to 16 beats with byte strobes.
// Ports:
//   aclk    - clock
//   aresetn - asynchronous active-low reset
//   s       - AXI bus, slave side (AR/R/AW/W/B channels)
// Parameters:
//   ADDR_WIDTH - word-index bits
//   RD_DELAY   - idle cycles between AR handshake and first R beat
module axi4_sram_slave #(
   parameter int ADDR_WIDTH = 12,
   parameter int RD_DELAY   = 1
) (
   input  logic              aclk,
   input  logic              aresetn,
   axi4_sram_slave_if.slave  s
);

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RD_DATA,
      WR_DATA,
      WR_RESP
   } state_e;

   localparam logic [7:0] DLY_LOAD = (RD_DELAY > 0) ? 8'(RD_DELAY - 1) : '0;

   state_e                 state_q, state_d;
   logic                   wr_prio_q, wr_prio_d;
   logic [3:0]             id_q, id_d;
   logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
   logic [3:0]             len_q, len_d;
   logic [3:0]             beat_q, beat_d;
   logic                   fixed_q, fixed_d;
   logic [7:0]             dly_q, dly_d;
   logic                   err_q, err_d;

   logic [31:0]            mem [2**ADDR_WIDTH];
   logic                   mem_we;
   logic                   ar_rdy, aw_rdy;
   logic                   last_beat;
   logic [ADDR_WIDTH-1:0]  idx_next;

   // Fields the responder deliberately ignores (sizes, WID, aliased address bits)
   logic unused_ok;
   assign unused_ok = ^{s.araddr[31:ADDR_WIDTH+2], s.araddr[1:0],
                        s.awaddr[31:ADDR_WIDTH+2], s.awaddr[1:0],
                        s.arsize, s.awsize, s.wid};

   assign last_beat = (beat_q == len_q);
   // FIXED holds the index; INCR steps it and wraps within the RAM
   assign idx_next  = idx_q + ADDR_WIDTH'(!fixed_q);

   always_comb begin
      state_d   = state_q;
      wr_prio_d = wr_prio_q;
      id_d      = id_q;
      idx_d     = idx_q;
      len_d     = len_q;
      beat_d    = beat_q;
      fixed_d   = fixed_q;
      dly_d     = dly_q;
      err_d     = err_q;
      mem_we    = 1'b0;
      ar_rdy    = 1'b0;
      aw_rdy    = 1'b0;

      s.rvalid  = 1'b0;
      s.rdata   = '0;
      s.rid     = '0;
      s.rresp   = '0;
      s.rlast   = 1'b0;
      s.wready  = 1'b0;
      s.bvalid  = 1'b0;
      s.bid     = '0;
      s.bresp   = '0;

      case (state_q)
         IDLE: begin
            // Each ready is only withheld when the other side holds priority
            // and is requesting, so at most one handshake can occur.
            ar_rdy = ~(s.awvalid & wr_prio_q);
            aw_rdy = ~(s.arvalid & ~wr_prio_q);
            if (s.arvalid && ar_rdy) begin
               id_d      = s.arid;
               idx_d     = s.araddr[ADDR_WIDTH+1:2];
               len_d     = s.arlen;
               fixed_d   = (s.arburst == 2'b00);
               beat_d    = '0;
               dly_d     = DLY_LOAD;
               wr_prio_d = 1'b1;
               state_d   = (RD_DELAY == 0) ? RD_DATA : RD_WAIT;
            end else if (s.awvalid && aw_rdy) begin
               id_d      = s.awid;
               idx_d     = s.awaddr[ADDR_WIDTH+1:2];
               len_d     = s.awlen;
               fixed_d   = (s.awburst == 2'b00);
               beat_d    = '0;
               err_d     = 1'b0;
               wr_prio_d = 1'b0;
               state_d   = WR_DATA;
            end
         end
         RD_WAIT: begin
            if (dly_q == '0) state_d = RD_DATA;
            else             dly_d   = dly_q - 8'd1;
         end
         RD_DATA: begin
            s.rvalid = 1'b1;
            s.rdata  = mem[idx_q];
            s.rid    = id_q;
            s.rlast  = last_beat;
            if (s.rready) begin
               if (last_beat) begin
                  state_d = IDLE;
               end else begin
                  beat_d = beat_q + 4'd1;
                  idx_d  = idx_next;
               end
            end
         end
         WR_DATA: begin
            s.wready = 1'b1;
            if (s.wvalid) begin
               mem_we = 1'b1;
               // Beat count ends the burst; a disagreeing WLAST only flags SLVERR
               if (s.wlast != last_beat) err_d = 1'b1;
               if (last_beat) begin
                  state_d = WR_RESP;
               end else begin
                  beat_d = beat_q + 4'd1;
                  idx_d  = idx_next;
               end
            end
         end
         WR_RESP: begin
            s.bvalid = 1'b1;
            s.bid    = id_q;
            s.bresp  = err_q ? 2'b10 : 2'b00;
            if (s.bready) begin
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Readies are held low while reset is asserted
      s.arready = ar_rdy & aresetn;
      s.awready = aw_rdy & aresetn;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= IDLE;
         wr_prio_q <= 1'b0;
         id_q      <= '0;
         idx_q     <= '0;
         len_q     <= '0;
         beat_q    <= '0;
         fixed_q   <= 1'b0;
         dly_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_prio_q <= wr_prio_d;
         id_q      <= id_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
         beat_q    <= beat_d;
         fixed_q   <= fixed_d;
         dly_q     <= dly_d;
         err_q     <= err_d;
      end
   end

   // RAM contents survive reset
   always_ff @(posedge aclk) begin
      if (mem_we) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (s.wstrb[i]) mem[idx_q][8*i +: 8] <= s.wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave (ADDR_WIDTH=12, RD_DELAY=1).
module tb_axi4_sram_slave;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   axi4_sram_slave_if bus ();

   axi4_sram_slave #(.ADDR_WIDTH(12), .RD_DELAY(1)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .s       (bus)
   );

   always #5 aclk = ~aclk;

   localparam int W_AR = 0, W_AW = 1, W_W = 2, W_R = 3, W_B = 4;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   function automatic logic sig(input int w);
      case (w)
         W_AR:    return bus.arready;
         W_AW:    return bus.awready;
         W_W:     return bus.wready;
         W_R:     return bus.rvalid;
         default: return bus.bvalid;
      endcase
   endfunction

   // Returns one settle-delay before the handshake edge; on timeout records a failure.
   task automatic wait_for(input int w, input string tag);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 32; i++) begin
         #1;
         if (sig(w) === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      if (!ok) chk(tag, {31'b0, ok}, 32'd1);
   endtask

   task automatic aw(input logic [3:0] id, input logic [31:0] addr,
                     input logic [3:0] len, input logic [1:0] burst);
      bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awburst = burst;
      bus.awvalid = 1'b1;
      wait_for(W_AW, "aw_timeout");
      step();
      bus.awvalid = 1'b0;
   endtask

   task automatic wbeat(input logic [31:0] data, input logic [3:0] strb, input logic last);
      bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
      wait_for(W_W, "w_timeout");
      step();
      bus.wvalid = 1'b0;
   endtask

   task automatic bresp(input logic [3:0] id, input logic [1:0] resp);
      bus.bready = 1'b1;
      wait_for(W_B, "b_timeout");
      chk("bid", {28'b0, bus.bid}, {28'b0, id});
      chk("bresp", {30'b0, bus.bresp}, {30'b0, resp});
      step();
      bus.bready = 1'b0;
   endtask

   task automatic ar(input logic [3:0] id, input logic [31:0] addr,
                     input logic [3:0] len, input logic [1:0] burst);
      bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arburst = burst;
      bus.arvalid = 1'b1;
      wait_for(W_AR, "ar_timeout");
      step();
      bus.arvalid = 1'b0;
   endtask

   task automatic rbeat(input string tag, input logic [31:0] data, input logic [3:0] id,
                        input logic last, input logic chk_data);
      bus.rready = 1'b1;
      wait_for(W_R, "r_timeout");
      if (chk_data) chk(tag, bus.rdata, data);
      chk("rid", {28'b0, bus.rid}, {28'b0, id});
      chk("rlast", {31'b0, bus.rlast}, {31'b0, last});
      chk("rresp", {30'b0, bus.rresp}, 32'd0);
      step();
      bus.rready = 1'b0;
   endtask

   int beat;

   initial begin
      bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd2;
      bus.arburst = 2'b01; bus.arvalid = 1'b0; bus.rready = 1'b0;
      bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd2;
      bus.awburst = 2'b01; bus.awvalid = 1'b0;
      bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
      bus.wvalid = 1'b0; bus.bready = 1'b0;

      // Reset: hold low three cycles, all handshake outputs low
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_hs_outputs",
             {26'b0, bus.arready, bus.awready, bus.wready, bus.rvalid, bus.rlast, bus.bvalid}, 32'd0);
      end
      chk("rst_rdata", bus.rdata, 32'd0);
      chk("rst_ids", {24'b0, bus.rid, bus.bid}, 32'd0);
      aresetn = 1'b1;
      #1;
      chk("post_rst_readies", {30'b0, bus.arready, bus.awready}, 32'd3);

      // Arbitration: simultaneous after reset -> read first
      bus.arid = 4'd1; bus.araddr = 32'h300; bus.arlen = 4'd0; bus.arburst = 2'b01;
      bus.awid = 4'd2; bus.awaddr = 32'h304; bus.awlen = 4'd0; bus.awburst = 2'b01;
      bus.arvalid = 1'b1; bus.awvalid = 1'b1;
      #1;
      chk("arb0_ready", {30'b0, bus.arready, bus.awready}, 32'd2);
      step();
      bus.arvalid = 1'b0;
      #1;
      chk("arb0_busy_awready", {31'b0, bus.awready}, 32'd0);
      rbeat("arb0_rd", 32'd0, 4'd1, 1'b1, 1'b0);
      // Read done (write now has priority): both requesting -> write wins
      bus.arid = 4'd4; bus.araddr = 32'h304; bus.arvalid = 1'b1;
      #1;
      chk("arb1_ready", {30'b0, bus.arready, bus.awready}, 32'd1);
      step();
      bus.awvalid = 1'b0;
      wbeat(32'hCAFE0001, 4'hF, 1'b1);
      bresp(4'd2, 2'b00);
      // Write done: pending read plus a new write -> read wins
      bus.awid = 4'd6; bus.awaddr = 32'h308; bus.awvalid = 1'b1;
      #1;
      chk("arb2_ready", {30'b0, bus.arready, bus.awready}, 32'd2);
      step();
      bus.arvalid = 1'b0;
      rbeat("arb2_rd", 32'hCAFE0001, 4'd4, 1'b1, 1'b1);
      wait_for(W_AW, "arb2_aw_timeout");
      step();
      bus.awvalid = 1'b0;
      wbeat(32'h0BADF00D, 4'hF, 1'b1);
      bresp(4'd6, 2'b00);

      // Single write then read, first rvalid at T+2
      aw(4'd3, 32'h100, 4'd0, 2'b01);
      wbeat(32'hDEADBEEF, 4'hF, 1'b1);
      bresp(4'd3, 2'b00);
      ar(4'd5, 32'h100, 4'd0, 2'b01);
      #1;
      chk("rd_delay_t1_rvalid", {31'b0, bus.rvalid}, 32'd0);
      step();
      chk("rd_delay_t2_rvalid", {31'b0, bus.rvalid}, 32'd1);
      rbeat("single_rd", 32'hDEADBEEF, 4'd5, 1'b1, 1'b1);

      // 8-beat INCR burst, read back with rready toggling
      aw(4'd7, 32'h200, 4'd7, 2'b01);
      for (int i = 0; i < 8; i++) wbeat(32'(i), 4'hF, (i == 7));
      bresp(4'd7, 2'b00);
      ar(4'd8, 32'h200, 4'd7, 2'b01);
      beat = 0;
      for (int cyc = 0; cyc < 64 && beat < 8; cyc++) begin
         bus.rready = cyc[0];
         #1;
         if (bus.rvalid) begin
            chk("burst_rdata", bus.rdata, 32'(beat));
            chk("burst_rlast", {31'b0, bus.rlast}, {31'b0, (beat == 7)});
            if (bus.rready) beat++;
         end
         step();
      end
      bus.rready = 1'b0;
      chk("burst_beats", 32'(beat), 32'd8);
      #1;
      chk("burst_rvalid_after", {31'b0, bus.rvalid}, 32'd0);

      // Partial strobe over existing word
      aw(4'd1, 32'h400, 4'd0, 2'b01);
      wbeat(32'hDEADBEEF, 4'hF, 1'b1);
      bresp(4'd1, 2'b00);
      aw(4'd1, 32'h400, 4'd0, 2'b01);
      wbeat(32'h12345678, 4'b0011, 1'b1);
      bresp(4'd1, 2'b00);
      ar(4'd2, 32'h402, 4'd0, 2'b01);
      rbeat("strobe_rd", 32'hDEAD5678, 4'd2, 1'b1, 1'b1);

      // FIXED burst: all beats land in one word; FIXED read repeats it
      aw(4'd11, 32'h700, 4'd2, 2'b00);
      for (int i = 0; i < 3; i++) wbeat(32'hF0 + 32'(i), 4'hF, (i == 2));
      bresp(4'd11, 2'b00);
      ar(4'd12, 32'h700, 4'd1, 2'b00);
      rbeat("fixed_rd0", 32'hF2, 4'd12, 1'b0, 1'b1);
      rbeat("fixed_rd1", 32'hF2, 4'd12, 1'b1, 1'b1);

      // Early WLAST on beat 2 of 4: all beats written, SLVERR, then clean OKAY
      aw(4'd9, 32'h500, 4'd3, 2'b01);
      for (int i = 0; i < 4; i++) wbeat(32'hA0 + 32'(i), 4'hF, (i == 1));
      bresp(4'd9, 2'b10);
      ar(4'd9, 32'h500, 4'd3, 2'b01);
      for (int i = 0; i < 4; i++) rbeat("err_burst_rd", 32'hA0 + 32'(i), 4'd9, (i == 3), 1'b1);
      aw(4'd10, 32'h600, 4'd0, 2'b01);
      wbeat(32'h55AA55AA, 4'hF, 1'b1);
      bresp(4'd10, 2'b00);

      // Reset mid-burst: no further beats after release
      ar(4'd13, 32'h200, 4'd3, 2'b01);
      rbeat("midrst_rd0", 32'd0, 4'd13, 1'b0, 1'b1);
      aresetn = 1'b0;
      bus.rready = 1'b1;
      #1;
      chk("midrst_rvalid_in_rst", {31'b0, bus.rvalid}, 32'd0);
      step();
      aresetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("midrst_rvalid_after", {31'b0, bus.rvalid}, 32'd0);
         step();
      end
      bus.rready = 1'b0;
      // RAM survives reset
      ar(4'd14, 32'h600, 4'd0, 2'b01);
      rbeat("midrst_mem_kept", 32'h55AA55AA, 4'd14, 1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/axi4_sram_slave.md
Name: axi4_sram_slave

Overview:
- AXI4 (AXI3-style ID/WID, 4-bit LEN) responder backed by an internal word-addressed RAM.
- Forms the memory end of the CPU's external AXI master bus; used as the bench/FPGA memory model for cache refill, write-back and uncached traffic.
- One outstanding transaction at a time, read or write.
- Supports FIXED and INCR bursts of up to 16 beats, 32-bit data, with byte strobes.

Parameters:
ADDR_WIDTH, 12, word-index bits; memory holds 2^ADDR_WIDTH 32-bit words.
RD_DELAY, 1, idle cycles inserted between AR handshake and first R beat (0 allowed).

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
arid  in  4  read ID
araddr  in  32  read byte address
arlen  in  4  read beats minus 1
arsize  in  3  ignored (32-bit only)
arburst  in  2  00 FIXED, otherwise INCR
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  4  read ID echo
rdata  out  32  read data
rresp  out  2  always 00
rlast  out  1  last read beat
rvalid  out  1  R valid
rready  in  1  R ready
awid  in  4  write ID
awaddr  in  32  write byte address
awlen  in  4  write beats minus 1
awsize  in  3  ignored
awburst  in  2  00 FIXED, otherwise INCR
awvalid  in  1  AW valid
awready  out  1  AW ready
wid  in  4  ignored
wdata  in  32  write data
wstrb  in  4  byte enables
wlast  in  1  last write beat
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  4  write ID echo
bresp  out  2  00 OKAY, 10 SLVERR
bvalid  out  1  B valid
bready  in  1  B ready

Behaviour:
- States: IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP.
- Reset (aresetn low, asynchronous):
  - state IDLE; wr_prio=0.
  - arready, awready, wready, rvalid, rlast, bvalid forced 0; rid, rdata, rresp, bid, bresp = 0.
  - RAM contents not reset.
  - Reset mid-burst abandons the transaction; no further beats are issued after release.
- IDLE arbitration:
  - arready = ~(awvalid & wr_prio).
  - awready = ~(arvalid & ~wr_prio).
  - Exactly one handshake per cycle. If both valids are high, the side whose priority bit wins is accepted.
  - After a read accept, wr_prio=1; after a write accept, wr_prio=0.
  - ready is 0 in every non-IDLE state.
- Address handling:
  - Word index = addr[ADDR_WIDTH+1:2]; upper bits alias; addr[1:0] ignored.
  - INCR adds 1 to the index per beat, wrapping modulo 2^ADDR_WIDTH.
  - FIXED keeps the index constant.
- Read path:
  - AR handshake latches id, index, len, burst.
  - Goes to RD_WAIT for RD_DELAY cycles, or directly to RD_DATA if RD_DELAY=0.
  - First rvalid appears at cycle T+1+RD_DELAY, where T is the AR handshake cycle.
  - In RD_DATA: rvalid=1, rdata=mem[current index], rid=latched id, rresp=00, rlast=(beat==len).
  - Outputs are held stable while rvalid & ~rready.
  - On rvalid & rready: advance beat/index; the next beat is valid the following cycle, i.e. back-to-back at full throughput.
  - After the last beat handshake, return to IDLE; rvalid=0 next cycle.
- Write path:
  - AW handshake latches id, index, len, burst; go to WR_DATA. W is never accepted before its AW (wready=0 in IDLE).
  - In WR_DATA, wready=1. On wvalid & wready, write each byte i of mem[index] where wstrb[i]=1, then advance.
  - Beat count is authoritative: WR_DATA ends after len+1 beats.
  - If wlast disagrees with (beat==len) on any beat, a sticky error is set and bresp=10; otherwise bresp=00.
  - After the final beat, go to WR_RESP: bvalid=1, bid=latched id. Hold until bready, then go to IDLE and clear the sticky error.
- A read issued after a write completes (after B handshake) observes the written data.

Test Plan:
- Reset check:
  - Stimulus: hold aresetn low for 3 cycles, then release with no valids.
  - Required: all valid and ready outputs are 0 during reset; arready=awready=1 in the first cycle after release.
- Single write then read:
  - Stimulus: AW awaddr=0x100, awid=3, len=0; W wdata=0xDEADBEEF, wstrb=1111, wlast=1. Then AR to 0x100, arid=5.
  - Required: B with bid=3, bresp=00. R with rdata=0xDEADBEEF, rid=5, rlast=1, rvalid at T+2 for RD_DELAY=1.
- INCR burst with backpressure:
  - Stimulus: 8-beat write at 0x200 with data 0..7. Read back with arlen=7 while rready toggles every cycle.
  - Required: rdata returns 0..7 in order, held stable during stalls; rlast only on beat 8; exactly 8 beat handshakes.
- Partial strobe:
  - Stimulus: write 0x12345678 with wstrb=0011 over 0xDEADBEEF.
  - Required: readback 0xDEAD5678.
- Arbitration:
  - Stimulus: arvalid and awvalid asserted together right after reset, and again after both complete.
  - Required: read granted first, write second. On the next simultaneous request, after the write the read is granted first.
- Protocol error:
  - Stimulus: awlen=3 with wlast asserted on beat 2.
  - Required: all 4 beats written, bresp=10. A following clean write returns bresp=00.
